trade_history_buffer: RTL and testbench

Records every executed trade price from the matching engine into a circular history and serves it to the VGA analytics renderer through a registered random-read port. It sits directly downstream of `matching_engine`, consuming `match_signal` and `trade_price` in the `clk_50` domain. It also keeps session statistics (last, low, high, 8-trade moving average) for on-screen overlays. The block is purely an observer: it never back-pressures the engine.

---
 rtl/trade_history_buffer.sv | 158 +++++++++++++++
 tb/tb_trade_history_buffer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/trade_history_buffer.sv
// Circular trade-price history with registered random-read port and session stats (TRADE_HIST_STATS_EN).
// Latency: stats/count update one cycle after a match edge; rd_data one cycle after rd_addr.
// Backpressure: none, pure observer of the matching engine; halted trades are counted, not stored.
module trade_history_buffer #(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int PRICE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               match_signal,
    input  logic [PRICE_W-1:0] trade_price,
    input  logic               halt,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [PRICE_W-1:0] rd_data,
    output logic [ADDR_W:0]    count,
    output logic               wrapped,
    output logic [7:0]         dropped,
    output logic [PRICE_W-1:0] last_price,
    output logic [PRICE_W-1:0] min_price,
    output logic [PRICE_W-1:0] max_price,
    output logic [PRICE_W-1:0] avg_price,
    output logic               avg_valid
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic               match_prev_q, match_prev_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               wrapped_q, wrapped_d;
    logic [7:0]         dropped_q, dropped_d;
    logic [PRICE_W-1:0] last_q, last_d;
    logic [PRICE_W-1:0] rd_data_q, rd_data_d;
    logic [PRICE_W-1:0] mem_q [DEPTH];
    logic               trade_ev, rec_en;
    logic [ADDR_W-1:0]  rd_phys;

    always_comb begin
        trade_ev     = match_signal & ~match_prev_q;
        rec_en       = trade_ev & ~halt;
        match_prev_d = match_signal;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        wrapped_d    = wrapped_q;
        dropped_d    = dropped_q;
        last_d       = last_q;
        if (rec_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            last_d   = trade_price;
            if (count_q == FULL_CNT) begin
                wrapped_d = 1'b1;
            end else begin
                count_d = count_q + (ADDR_W+1)'(1);
            end
        end
        if (trade_ev && halt && dropped_q != 8'hFF) begin
            dropped_d = dropped_q + 8'd1;
        end
        // Age 0 is the slot just behind the pre-write pointer, so same-cycle writes stay invisible.
        rd_phys   = wr_ptr_q - ADDR_W'(1) - rd_addr;
        rd_data_d = ({1'b0, rd_addr} >= count_q) ? '0 : mem_q[rd_phys];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_prev_q <= 1'b0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            wrapped_q    <= 1'b0;
            dropped_q    <= '0;
            last_q       <= '0;
            rd_data_q    <= '0;
        end else begin
            match_prev_q <= match_prev_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            wrapped_q    <= wrapped_d;
            dropped_q    <= dropped_d;
            last_q       <= last_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // No reset on storage: count masks stale entries.
    always_ff @(posedge clk) begin
        if (rec_en && !reset) begin
            mem_q[wr_ptr_q] <= trade_price;
        end
    end

    assign rd_data    = rd_data_q;
    assign count      = count_q;
    assign wrapped    = wrapped_q;
    assign dropped    = dropped_q;
    assign last_price = last_q;

`ifdef TRADE_HIST_STATS_EN
    logic [PRICE_W-1:0] lo_q, lo_d;
    logic [PRICE_W-1:0] hi_q, hi_d;
    logic [PRICE_W-1:0] min_q, min_d;
    logic [PRICE_W-1:0] avg_q, avg_d;
    logic               avg_valid_q, avg_valid_d;
    logic [PRICE_W-1:0] sh_q [8];
    logic [PRICE_W-1:0] sh_d [8];
    logic [PRICE_W+2:0] sum_q, sum_d;

    always_comb begin
        lo_d  = lo_q;
        hi_d  = hi_q;
        sh_d  = sh_q;
        sum_d = sum_q;
        if (rec_en) begin
            lo_d    = (trade_price < lo_q) ? trade_price : lo_q;
            hi_d    = (trade_price > hi_q) ? trade_price : hi_q;
            sh_d[0] = trade_price;
            for (int i = 1; i < 8; i++) begin
                sh_d[i] = sh_q[i-1];
            end
            sum_d = sum_q + (PRICE_W+3)'(trade_price) - (PRICE_W+3)'(sh_q[7]);
        end
        min_d       = (count_d == '0) ? '0 : lo_d;
        avg_valid_d = (count_d >= (ADDR_W+1)'(8));
        avg_d       = avg_valid_d ? sum_d[PRICE_W+2:3] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q        <= '1;
            hi_q        <= '0;
            min_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            sh_q        <= '{default: '0};
            sum_q       <= '0;
        end else begin
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            min_q       <= min_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            sh_q        <= sh_d;
            sum_q       <= sum_d;
        end
    end

    assign min_price = min_q;
    assign max_price = hi_q;
    assign avg_price = avg_q;
    assign avg_valid = avg_valid_q;
`else
    assign min_price = '0;
    assign max_price = '0;
    assign avg_price = '0;
    assign avg_valid = 1'b0;
`endif

endmodule

// File: tb/tb_trade_history_buffer.sv
// Directed scenarios plus random trading traffic, checked against a queue-based history model.
module tb_trade_history_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       match_signal;
    logic [7:0] trade_price;
    logic       halt;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] count;
    logic       wrapped;
    logic [7:0] dropped;
    logic [7:0] last_price, min_price, max_price, avg_price;
    logic       avg_valid;

    trade_history_buffer #(.DEPTH(64), .ADDR_W(6), .PRICE_W(8)) dut (
        .clk(clk), .reset(reset), .match_signal(match_signal), .trade_price(trade_price),
        .halt(halt), .rd_addr(rd_addr), .rd_data(rd_data), .count(count), .wrapped(wrapped),
        .dropped(dropped), .last_price(last_price), .min_price(min_price), .max_price(max_price),
        .avg_price(avg_price), .avg_valid(avg_valid)
    );

    always #5 clk = ~clk;

`ifdef TRADE_HIST_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Reference model: newest trade at the front of the queue.
    logic [7:0] hist[$];
    bit         m_prev;
    bit         m_wrapped;
    int         m_dropped;
    int         m_last, m_lo, m_hi;
    int         vectors = 0;
    int         errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_prev    = 1'b0;
        m_wrapped = 1'b0;
        m_dropped = 0;
        m_last    = 0;
        m_lo      = 255;
        m_hi      = 0;
    endtask

    task automatic step(input bit m, input int p, input bit h, input int ra, input bit rst);
        int  exp_rd, n, s, exp_avg;
        bit  ev;
        match_signal = m;
        trade_price  = 8'(p);
        halt         = h;
        rd_addr      = 6'(ra);
        reset        = rst;
        exp_rd = (!rst && ra < hist.size()) ? int'(hist[ra]) : 0;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            ev     = m && !m_prev;
            m_prev = m;
            if (ev && h) begin
                if (m_dropped < 255) m_dropped++;
            end else if (ev) begin
                if (hist.size() == 64) begin
                    m_wrapped = 1'b1;
                    void'(hist.pop_back());
                end
                hist.push_front(8'(p));
                m_last = p;
                if (p < m_lo) m_lo = p;
                if (p > m_hi) m_hi = p;
            end
        end
        n = hist.size();
        s = 0;
        if (n >= 8) for (int i = 0; i < 8; i++) s += int'(hist[i]);
        exp_avg = (STATS && n >= 8) ? s / 8 : 0;
        chk("rd_data",    32'(rd_data),    32'(exp_rd));
        chk("count",      32'(count),      32'(n));
        chk("wrapped",    32'(wrapped),    32'(m_wrapped));
        chk("dropped",    32'(dropped),    32'(m_dropped));
        chk("last_price", 32'(last_price), 32'(m_last));
        chk("min_price",  32'(min_price),  32'((STATS && n > 0) ? m_lo : 0));
        chk("max_price",  32'(max_price),  32'(STATS ? m_hi : 0));
        chk("avg_price",  32'(avg_price),  32'(exp_avg));
        chk("avg_valid",  32'(avg_valid),  32'(STATS && n >= 8));
    endtask

    task automatic pulse(input int p, input bit h);
        step(1'b1, p, h, $urandom_range(0, 63), 1'b0);
        step(1'b0, 0, h, $urandom_range(0, 63), 1'b0);
    endtask

    initial begin
        model_reset();
        match_signal = 1'b0;
        trade_price  = '0;
        halt         = 1'b0;
        rd_addr      = '0;
        reset        = 1'b1;

        step(1'b0, 0, 1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0, 0, 1'b1);

        // Three trades, then read ages 0..3 including one past count.
        pulse(10, 1'b0);
        pulse(20, 1'b0);
        pulse(30, 1'b0);
        for (int a = 0; a < 4; a++) step(1'b0, 0, 1'b0, a, 1'b0);

        // Long high level logs a single trade.
        for (int i = 0; i < 5; i++) step(1'b1, 55, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0, 0, 1'b0);

        // Moving average across the 8-trade boundary.
        step(1'b0, 0, 1'b0, 0, 1'b1);
        for (int p = 1; p <= 8; p++) pulse(p, 1'b0);
        pulse(16, 1'b0);

        // Fill past depth to force a wrap.
        step(1'b0, 0, 1'b0, 0, 1'b1);
        for (int p = 0; p <= 64; p++) pulse(p, 1'b0);
        step(1'b0, 0, 1'b0, 63, 1'b0);
        step(1'b0, 0, 1'b0, 0, 1'b0);

        // Halted trades are counted but not stored.
        for (int i = 0; i < 3; i++) pulse(200 + i, 1'b1);
        pulse(77, 1'b0);
        step(1'b0, 0, 1'b0, 0, 1'b0);

        // Reset colliding with an edge, then match held high through release.
        step(1'b0, 0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) pulse(40 + i, 1'b0);
        step(1'b1, 99, 1'b0, 0, 1'b1);
        step(1'b1, 98, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0, 0, 1'b0);

        // Random traffic with occasional halts and resets.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 255),
                 ($urandom_range(0, 7) == 0), $urandom_range(0, 63),
                 ($urandom_range(0, 599) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
